// File: rtl/wb_mux_guarded.sv
// Single-master, N-slave Wishbone mux with registered decode, per-cycle slave lock,
// unmapped-address error response and a response-timeout watchdog.
module wb_mux_guarded #(
  parameter int unsigned                  NUM_SLAVES     = 8,
  parameter int unsigned                  AW             = 32,
  parameter int unsigned                  DW             = 32,
  parameter logic [NUM_SLAVES*AW-1:0]     MATCH_ADDR     = '0,
  parameter logic [NUM_SLAVES*AW-1:0]     MATCH_MASK     = '0,
  parameter int unsigned                  TIMEOUT_CYCLES = 255,
  parameter int unsigned                  TW             = 8
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_n_i,
  // master port
  input  logic [AW-1:0]                  wbm_adr_i,
  input  logic [DW-1:0]                  wbm_dat_i,
  input  logic [DW/8-1:0]                wbm_sel_i,
  input  logic                           wbm_we_i,
  input  logic                           wbm_cyc_i,
  input  logic                           wbm_stb_i,
  input  logic [2:0]                     wbm_cti_i,
  input  logic [1:0]                     wbm_bte_i,
  output logic [DW-1:0]                  wbm_dat_o,
  output logic                           wbm_ack_o,
  output logic                           wbm_err_o,
  output logic                           wbm_rty_o,
  // slave ports
  output logic [NUM_SLAVES*AW-1:0]       wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]       wbs_dat_o,
  output logic [NUM_SLAVES*(DW/8)-1:0]   wbs_sel_o,
  output logic [NUM_SLAVES-1:0]          wbs_we_o,
  output logic [NUM_SLAVES-1:0]          wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]          wbs_stb_o,
  output logic [NUM_SLAVES*3-1:0]        wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]        wbs_bte_o,
  input  logic [NUM_SLAVES*DW-1:0]       wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]          wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]          wbs_err_i,
  input  logic [NUM_SLAVES-1:0]          wbs_rty_i,
  // fault status
  output logic                           timeout_o,
  output logic                           decode_err_o,
  output logic [AW-1:0]                  fault_adr_o
);

  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam bit          WdEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] LastCnt = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StActive, StErr, StWait} state_e;

  state_e          state_q;
  logic [SW-1:0]   sel_idx_q;
  logic [TW-1:0]   cnt_q;
  logic [AW-1:0]   fault_adr_q;

  logic [NUM_SLAVES-1:0] hit_vec;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  dec_hit;
  logic [SW-1:0]         dec_idx;
  logic                  sel_ack, sel_err, sel_rty, sel_resp;
  logic [DW-1:0]         sel_dat;
  logic                  req, active, wd_fire;

  // Broadcast everything except the handshake strobes.
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    assign hit_vec[g] = ((wbm_adr_i & MATCH_MASK[g*AW +: AW]) ==
                         (MATCH_ADDR[g*AW +: AW] & MATCH_MASK[g*AW +: AW]));
    assign sel_oh[g]  = (sel_idx_q == SW'(g));
  end

  // Lowest-index hit wins when decode windows overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (hit_vec[i] && !dec_hit) begin
        dec_hit = 1'b1;
        dec_idx = SW'(i);
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_oh[i]) begin
        sel_dat = wbs_dat_i[i*DW +: DW];
      end
    end
  end

  assign sel_ack  = |(wbs_ack_i & sel_oh);
  assign sel_err  = |(wbs_err_i & sel_oh);
  assign sel_rty  = |(wbs_rty_i & sel_oh);
  assign sel_resp = sel_ack | sel_err | sel_rty;

  assign req    = wbm_cyc_i & wbm_stb_i;
  assign active = (state_q == StActive);

  // A response on the firing cycle suppresses the timeout.
  assign wd_fire = WdEn && active && req && !sel_resp && (cnt_q == LastCnt);

  always_comb begin
    wbs_cyc_o    = '0;
    wbs_stb_o    = '0;
    wbm_ack_o    = 1'b0;
    wbm_err_o    = 1'b0;
    wbm_rty_o    = 1'b0;
    wbm_dat_o    = '0;
    decode_err_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        decode_err_o = wb_rst_n_i & req & ~dec_hit;
      end
      StActive: begin
        wbs_cyc_o = sel_oh & {NUM_SLAVES{wbm_cyc_i}};
        wbs_stb_o = sel_oh & {NUM_SLAVES{wbm_stb_i}};
        wbm_ack_o = wbm_cyc_i & sel_ack;
        wbm_err_o = wbm_cyc_i & sel_err;
        wbm_rty_o = wbm_cyc_i & sel_rty;
        wbm_dat_o = sel_dat;
      end
      StErr: begin
        wbm_err_o = req;
      end
      StWait: begin
      end
      default: begin
      end
    endcase
  end

  assign timeout_o   = wd_fire;
  assign fault_adr_o = fault_adr_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= StIdle;
      sel_idx_q   <= '0;
      cnt_q       <= '0;
      fault_adr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (req) begin
            if (dec_hit) begin
              state_q   <= StActive;
              sel_idx_q <= dec_idx;
            end else begin
              state_q     <= StErr;
              fault_adr_q <= wbm_adr_i;
            end
          end
        end
        StActive: begin
          if (!wbm_cyc_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (wd_fire) begin
            state_q     <= StErr;
            cnt_q       <= '0;
            fault_adr_q <= wbm_adr_i;
          end else if (!wbm_stb_i || sel_resp || !WdEn) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StErr: begin
          state_q <= StWait;
        end
        StWait: begin
          // Master must drop cyc before another transfer is accepted.
          if (!wbm_cyc_i) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mux_guarded.sv
// Directed bench for wb_mux_guarded: bus-ownership model checked every cycle plus literal checks.
module tb_wb_mux_guarded;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 16;
  // slave3 overlaps slave2 (0x2000-0x3FFF) to exercise priority and lock.
  localparam logic [NS*32-1:0] BASES_P = {32'h0000_2000, 32'h0000_2000, 32'h0000_1000,
                                           32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS_P = {32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000,
                                           32'hFFFF_F000};
  localparam logic [31:0] BASE_A [NS] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000,
                                           32'h0000_2000};
  localparam logic [31:0] MASK_A [NS] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
                                           32'hFFFF_E000};

  logic clk;
  logic rst_n;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic [31:0] s_dat [NS];
  logic [NS-1:0] s_ack, s_err, s_rty;
  logic [NS*32-1:0] s_dat_bus;

  logic [31:0]      wbm_dat_o;
  logic             wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [NS*32-1:0] wbs_adr_o, wbs_dat_o;
  logic [NS*4-1:0]  wbs_sel_o;
  logic [NS-1:0]    wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [NS*3-1:0]  wbs_cti_o;
  logic [NS*2-1:0]  wbs_bte_o;
  logic             timeout_o, decode_err_o;
  logic [31:0]      fault_adr_o;

  for (genvar g = 0; g < NS; g++) begin : g_dat
    assign s_dat_bus[g*32 +: 32] = s_dat[g];
  end

  wb_mux_guarded #(
    .NUM_SLAVES     (NS),
    .AW             (32),
    .DW             (32),
    .MATCH_ADDR     (BASES_P),
    .MATCH_MASK     (MASKS_P),
    .TIMEOUT_CYCLES (TO),
    .TW             (8)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .wbm_adr_i    (m_adr),
    .wbm_dat_i    (m_dat),
    .wbm_sel_i    (m_sel),
    .wbm_we_i     (m_we),
    .wbm_cyc_i    (m_cyc),
    .wbm_stb_i    (m_stb),
    .wbm_cti_i    (m_cti),
    .wbm_bte_i    (m_bte),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_ack_o    (wbm_ack_o),
    .wbm_err_o    (wbm_err_o),
    .wbm_rty_o    (wbm_rty_o),
    .wbs_adr_o    (wbs_adr_o),
    .wbs_dat_o    (wbs_dat_o),
    .wbs_sel_o    (wbs_sel_o),
    .wbs_we_o     (wbs_we_o),
    .wbs_cyc_o    (wbs_cyc_o),
    .wbs_stb_o    (wbs_stb_o),
    .wbs_cti_o    (wbs_cti_o),
    .wbs_bte_o    (wbs_bte_o),
    .wbs_dat_i    (s_dat_bus),
    .wbs_ack_i    (s_ack),
    .wbs_err_i    (s_err),
    .wbs_rty_i    (s_rty),
    .timeout_o    (timeout_o),
    .decode_err_o (decode_err_o),
    .fault_adr_o  (fault_adr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if ((a & MASK_A[k]) == (BASE_A[k] & MASK_A[k])) return k;
    end
    return -1;
  endfunction

  // Bus-ownership model: who owns the bus, pending error, blocked until cyc drops.
  int          m_owner = -1;
  bit          m_errnow = 1'b0;
  bit          m_blocked = 1'b0;
  int          m_stall = 0;
  logic [31:0] m_fault = '0;

  always @(negedge clk) begin
    logic [NS-1:0] e_cyc, e_stb;
    logic          e_ack, e_err, e_rty, e_derr, e_to, req, resp;
    logic [31:0]   e_dat;
    int            dec;
    bit            idle;
    if (!rst_n) begin
      m_owner = -1; m_errnow = 1'b0; m_blocked = 1'b0; m_stall = 0; m_fault = '0;
      chk("rst_slave_cyc", wbs_cyc_o, 0);
      chk("rst_slave_stb", wbs_stb_o, 0);
      chk("rst_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
      chk("rst_dat", wbm_dat_o, 0);
      chk("rst_flags", {timeout_o, decode_err_o}, 0);
      chk("rst_fault", fault_adr_o, 0);
    end else begin
      req  = m_cyc & m_stb;
      dec  = decode(m_adr);
      idle = (m_owner < 0) && !m_errnow && !m_blocked;
      e_cyc = '0; e_stb = '0; e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0;
      e_dat = '0; resp = 1'b0;
      for (int k = 0; k < NS; k++) begin
        if (k == m_owner) begin
          e_cyc[k] = m_cyc;
          e_stb[k] = m_stb;
          resp  = s_ack[k] | s_err[k] | s_rty[k];
          e_ack = m_cyc & s_ack[k];
          e_err = m_cyc & s_err[k];
          e_rty = m_cyc & s_rty[k];
          e_dat = s_dat[k];
        end
      end
      if (m_errnow) e_err = req;
      e_derr = idle && req && (dec < 0);
      e_to   = (m_owner >= 0) && req && !resp && (m_stall + 1 == int'(TO));

      chk("slave_cyc", wbs_cyc_o, e_cyc);
      chk("slave_stb", wbs_stb_o, e_stb);
      chk("m_ack", wbm_ack_o, e_ack);
      chk("m_err", wbm_err_o, e_err);
      chk("m_rty", wbm_rty_o, e_rty);
      chk("m_dat", wbm_dat_o, e_dat);
      chk("decode_err", decode_err_o, e_derr);
      chk("timeout", timeout_o, e_to);
      chk("fault_adr", fault_adr_o, m_fault);
      chk("bc_adr", wbs_adr_o, {NS{m_adr}});
      chk("bc_dat", wbs_dat_o, {NS{m_dat}});
      chk("bc_ctl", {wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_sel_o},
          {{NS{m_we}}, {NS{m_cti}}, {NS{m_bte}}, {NS{m_sel}}});

      if (e_derr || e_to) m_fault = m_adr;
      if (m_errnow) begin
        m_errnow  = 1'b0;
        m_blocked = 1'b1;
      end else if (m_blocked) begin
        if (!m_cyc) m_blocked = 1'b0;
      end else if (m_owner >= 0) begin
        if (!m_cyc) begin
          m_owner = -1; m_stall = 0;
        end else if (e_to) begin
          m_owner = -1; m_stall = 0; m_errnow = 1'b1;
        end else if (req && !resp) begin
          m_stall++;
        end else begin
          m_stall = 0;
        end
      end else if (req) begin
        if (dec >= 0) m_owner = dec;
        else          m_errnow = 1'b1;
        m_stall = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = 4'hF; m_we = 1'b0; m_cti = '0; m_bte = '0;
    s_ack = '0; s_err = '0; s_rty = '0;
    for (int k = 0; k < NS; k++) s_dat[k] = 32'h1111_1111 * (k + 1);
    // Request while in reset must not raise decode_err.
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h9000;
    #3;
    chk("rst_derr_gated", decode_err_o, 0);
    chk("rst_no_cyc", wbs_cyc_o, 0);
    repeat (2) @(posedge clk);
    #1 m_cyc = 1'b0; m_stb = 1'b0; m_adr = '0;
    step();
    rst_n = 1'b1;
    step();

    // Single read to slave1.
    m_adr = 32'h1004; m_cyc = 1'b1; m_stb = 1'b1;
    #1 chk("t1_idle_stb", wbs_stb_o, 4'b0000);
    step();
    s_ack[1] = 1'b1; s_dat[1] = 32'hDEAD_BEEF;
    #1;
    chk("t1_stb", wbs_stb_o, 4'b0010);
    chk("t1_ack", wbm_ack_o, 1);
    chk("t1_dat", wbm_dat_o, 32'hDEAD_BEEF);
    step();
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
    step();

    // Priority (slave2 over slave3) then locked 4-beat burst crossing 0x3000.
    m_adr = 32'h2FF8; m_cti = 3'b010; m_cyc = 1'b1; m_stb = 1'b1;
    s_ack[3] = 1'b1; s_dat[3] = 32'h3333_3333;
    step();
    for (int b = 0; b < 4; b++) begin
      m_adr = 32'h2FF8 + 32'(b * 4);
      m_cti = (b == 3) ? 3'b111 : 3'b010;
      s_ack[2] = 1'b1; s_dat[2] = 32'hB000_0000 + 32'(b);
      #1;
      chk("t2_stb", wbs_stb_o, 4'b0100);
      chk("t2_ack", wbm_ack_o, 1);
      chk("t2_dat", wbm_dat_o, 32'hB000_0000 + 32'(b));
      step();
    end
    m_cyc = 1'b0; m_stb = 1'b0; m_cti = '0; s_ack = '0;
    step();

    // Unmapped access.
    m_adr = 32'h9000; m_cyc = 1'b1; m_stb = 1'b1;
    #1;
    chk("t3_derr", decode_err_o, 1);
    chk("t3_nocyc", wbs_cyc_o, 0);
    step();
    s_ack = '1;
    #1;
    chk("t3_err", wbm_err_o, 1);
    chk("t3_derr_once", decode_err_o, 0);
    chk("t3_fault", fault_adr_o, 32'h9000);
    chk("t3_nocyc_err", wbs_cyc_o, 0);
    repeat (5) begin
      step();
      chk("t3_hold_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
      chk("t3_hold_cyc", wbs_cyc_o, 0);
    end
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
    step();

    // Watchdog timeout on slave0, late ack in WAIT.
    m_adr = 32'h0100; m_cyc = 1'b1; m_stb = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      chk("t4_no_to", timeout_o, 0);
      step();
    end
    chk("t4_to", timeout_o, 1);
    chk("t4_stb", wbs_stb_o, 4'b0001);
    chk("t4_no_err_yet", wbm_err_o, 0);
    step();
    chk("t4_err", wbm_err_o, 1);
    chk("t4_cyc_off", wbs_cyc_o, 0);
    chk("t4_fault", fault_adr_o, 32'h0100);
    step();
    s_ack[0] = 1'b1;
    #1;
    chk("t4_late_ack", wbm_ack_o, 0);
    chk("t4_wait_err", wbm_err_o, 0);
    step();
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
    step();

    // Ack on exactly the firing cycle wins.
    m_adr = 32'h1000; m_cyc = 1'b1; m_stb = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    s_ack[1] = 1'b1; s_dat[1] = 32'hCAFE_F00D;
    #1;
    chk("t5_ack", wbm_ack_o, 1);
    chk("t5_dat", wbm_dat_o, 32'hCAFE_F00D);
    chk("t5_no_to", timeout_o, 0);
    chk("t5_no_err", wbm_err_o, 0);
    step();
    s_ack = '0;
    #1;
    chk("t5_still_active", wbs_stb_o, 4'b0010);
    chk("t5_no_err_after", wbm_err_o, 0);
    m_cyc = 1'b0; m_stb = 1'b0;
    step();

    // Asynchronous reset mid-ACTIVE.
    m_adr = 32'h0200; m_cyc = 1'b1; m_stb = 1'b1;
    step();
    #1 chk("t6_cyc_on", wbs_cyc_o, 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", wbs_cyc_o, 0);
    chk("t6_rst_stb", wbs_stb_o, 0);
    chk("t6_rst_fault", fault_adr_o, 0);
    m_cyc = 1'b0; m_stb = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Write with rty then err pass-through.
    m_adr = 32'h0010; m_we = 1'b1; m_dat = 32'h1234_5678; m_sel = 4'h3;
    m_cyc = 1'b1; m_stb = 1'b1;
    step();
    s_rty[0] = 1'b1;
    #1;
    chk("t7_rty", wbm_rty_o, 1);
    chk("t7_no_ack", wbm_ack_o, 0);
    step();
    s_rty = '0; s_err[0] = 1'b1;
    #1 chk("t7_err", wbm_err_o, 1);
    step();
    s_err = '0; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
